// File: rtl/display7_pkg.sv
// Shared types and constants for the display7 line encoder: sizes, FSM states
// and the line-to-select-code table.
package display7_pkg;

  localparam int LINE_W    = 64;
  localparam int IDX_W     = $clog2(LINE_W);
  localparam int NUM_CODES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Only these lines have a defined select code; every other line misses.
  localparam logic [IDX_W-1:0] CODE_IDX [NUM_CODES] = '{6'd3, 6'd46, 6'd61};
  localparam logic [3:0]       CODE_VAL [NUM_CODES] = '{4'b1110, 4'b0000, 4'b0000};

  function automatic logic [4:0] line_code(input logic [IDX_W-1:0] idx);
    logic [4:0] res;
    res = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      if (idx == CODE_IDX[k]) res = {1'b1, CODE_VAL[k]};
    end
    return res;
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit finder over the line vector.
module lsb_priority_enc
  import display7_pkg::*;
(
  input  logic [LINE_W-1:0] vec_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = LINE_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/display7_line_encoder.sv
// Serialises a line vector into one beat per set line, lowest index first,
// each beat carrying the index and its display7 select code.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// SCAN  | pick lowest remaining line, load output registers
// EMIT  | beat presented, hold until out_ready
module display7_line_encoder
  import display7_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_lines,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [3:0]        out_code,
  output logic              out_hit,
  output logic              out_none,
  output logic              out_last
);

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   mask_q, mask_d, mask_clr;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          code_q, code_d;
  logic                hit_q, hit_d;
  logic                none_q, none_d;
  logic                last_q, last_d;
  logic                enc_found;
  logic [IDX_W-1:0]    enc_idx;

  lsb_priority_enc u_enc (
    .vec_i   (mask_q),
    .found_o (enc_found),
    .idx_o   (enc_idx)
  );

  assign mask_clr  = mask_q & ~(LINE_W'(1) << enc_idx);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx_q;
  assign out_code  = code_q;
  assign out_hit   = hit_q;
  assign out_none  = none_q;
  assign out_last  = last_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    code_d  = code_q;
    hit_d   = hit_q;
    none_d  = none_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d = in_lines;
          if (in_lines == '0) begin
            state_d = EMIT;
            idx_d   = '0;
            code_d  = '0;
            hit_d   = 1'b0;
            none_d  = 1'b1;
            last_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (enc_found) begin
          {hit_d, code_d} = line_code(enc_idx);
          idx_d   = enc_idx;
          none_d  = 1'b0;
          mask_d  = mask_clr;
          last_d  = (mask_clr == '0);
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) state_d = last_q ? IDLE : SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      hit_q   <= 1'b0;
      none_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      hit_q   <= hit_d;
      none_q  <= none_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_display7_line_encoder.sv
// Self-checking bench for display7_line_encoder against a list-based model.
module tb_display7_line_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_lines;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic [3:0]  out_code;
  logic        out_hit;
  logic        out_none;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  display7_line_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lines  (in_lines),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_code  (out_code),
    .out_hit   (out_hit),
    .out_none  (out_none),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_code(input int line);
    case (line)
      3:       return 5'b1_1110;
      46:      return 5'b1_0000;
      61:      return 5'b1_0000;
      default: return 5'b0_0000;
    endcase
  endfunction

  task automatic check_beat(input string tag, input int line, input bit zero_vec, input bit last);
    logic [4:0] rc;
    rc = zero_vec ? 5'b0 : ref_code(line);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_idx"},   out_idx, zero_vec ? 0 : line);
    chk({tag, "_code"},  out_code, rc[3:0]);
    chk({tag, "_hit"},   out_hit, rc[4]);
    chk({tag, "_none"},  out_none, zero_vec);
    chk({tag, "_last"},  out_last, last);
    chk({tag, "_inrdy"}, in_ready, 0);
  endtask

  // Called #1 after the acceptance edge; drains all expected beats.
  task automatic collect(input logic [63:0] v, input int max_hold,
                         input int fixed_beat, input int fixed_hold);
    int exp_q[$];
    bit zv;
    int n, hold;
    zv = (v == 0);
    if (zv) exp_q.push_back(0);
    else for (int i = 0; i < 64; i++) if (v[i]) exp_q.push_back(i);
    if (!zv) begin
      chk("scan_no_valid", out_valid, 0);
      chk("scan_inrdy", in_ready, 0);
    end
    for (int b = 0; b < exp_q.size(); b++) begin
      n = 0;
      while (!out_valid && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) begin
        chk("beat_timeout", 0, 1);
        return;
      end
      if (b == 0 && !zv) chk("first_latency", n, 1);
      check_beat("beat", exp_q[b], zv, b == exp_q.size() - 1);
      hold = (b == fixed_beat) ? fixed_hold : $urandom_range(0, max_hold);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check_beat("hold", exp_q[b], zv, b == exp_q.size() - 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_hs_valid", out_valid, 0);
    end
    chk("done_inrdy", in_ready, 1);
  endtask

  task automatic send(input logic [63:0] v, input int max_hold,
                      input int fixed_beat, input int fixed_hold);
    @(negedge clk);
    chk("accept_inrdy", in_ready, 1);
    in_lines = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(v, max_hold, fixed_beat, fixed_hold);
  endtask

  logic [63:0] rv;
  int n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_lines = '0; out_ready = 1'b0;
    #12;
    chk("rst_inrdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_code", out_code, 0);
    chk("rst_flags", {out_hit, out_none, out_last}, 0);
    @(negedge clk); rst_n = 1'b1;

    send(64'h1 << 3, 0, -1, 0);
    send((64'h1 << 3) | (64'h1 << 46) | (64'h1 << 61), 0, 1, 5);
    send(64'h0, 1, -1, 0);
    send(64'h1, 0, -1, 0);
    send(64'h1 << 63, 0, -1, 0);
    send({64{1'b1}}, 0, -1, 0);

    // Reset during the second beat of {3,46,61}.
    @(negedge clk);
    in_lines = (64'h1 << 3) | (64'h1 << 46) | (64'h1 << 61);
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk("rst_mid_b0_idx", out_idx, 3);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk("rst_mid_b1_idx", out_idx, 46);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_valid", out_valid, 0);
    chk("async_inrdy", in_ready, 1);
    chk("async_idx", out_idx, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    send(64'h1 << 63, 0, -1, 0);

    // New vector held on in_valid while busy is taken only once IDLE.
    @(negedge clk);
    in_lines = (64'h1 << 5) | (64'h1 << 9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_lines = (64'h1 << 3) | (64'h1 << 40);
    collect((64'h1 << 5) | (64'h1 << 9), 2, -1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect((64'h1 << 3) | (64'h1 << 40), 2, -1, 0);

    for (int t = 0; t < 30; t++) begin
      rv = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rv = rv & {$urandom, $urandom} & {$urandom, $urandom};
        1: rv = rv & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: rv = 64'h1 << $urandom_range(0, 63);
        default: ;
      endcase
      send(rv, 3, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
